// File: rtl/sumador_pkg.sv
// Shared constants for the adder display path: segment patterns, digit indices
// and the binary-to-decimal split of a captured result.
package sumador_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned AN_W  = 2;
  localparam int unsigned BIN_W = 6;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam int unsigned DIG_UNI = 0;
  localparam int unsigned DIG_DEC = 1;

  localparam logic [AN_W-1:0] AN_UNI  = AN_W'(1 << DIG_UNI);
  localparam logic [AN_W-1:0] AN_DEC  = AN_W'(1 << DIG_DEC);
  localparam logic [AN_W-1:0] AN_NONE = '0;

  typedef struct packed {
    logic [DIG_W-1:0] tens;
    logic [DIG_W-1:0] units;
  } bcd_t;

  // Results never exceed 63, so tens stays within 0..6
  function automatic bcd_t to_bcd(input logic [BIN_W-1:0] bin);
    bcd_t r;
    r.tens  = DIG_W'(bin / BIN_W'(10));
    r.units = DIG_W'(bin % BIN_W'(10));
    return r;
  endfunction

endpackage

// File: rtl/display_suma_dec7seg.sv
// Combinational decimal digit to active-high 7-segment pattern; non-decimal codes go blank.
module dec7seg
  import sumador_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [SEG_W-1:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_BLANK;
    case (digit)
      4'd0:    pattern_c = SEG_0;
      4'd1:    pattern_c = SEG_1;
      4'd2:    pattern_c = SEG_2;
      4'd3:    pattern_c = SEG_3;
      4'd4:    pattern_c = SEG_4;
      4'd5:    pattern_c = SEG_5;
      4'd6:    pattern_c = SEG_6;
      4'd7:    pattern_c = SEG_7;
      4'd8:    pattern_c = SEG_8;
      4'd9:    pattern_c = SEG_9;
      default: pattern_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_suma.sv
// Captures the adder result {Cout,S} on load and shows it in decimal on two
// time-multiplexed 7-segment digits; dark until the first capture after reset.
module display_suma
  import sumador_pkg::*;
#(
  parameter int unsigned N_BITS      = 3,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] S,
  input  logic              Cout,
  input  logic              load,
  output logic [SEG_W-1:0]  seg,
  output logic [AN_W-1:0]   an,
  output logic              valid
);

  localparam int unsigned RES_W = N_BITS + 1;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_POL  = {SEG_W{ACTIVE_LOW}};
  localparam logic [AN_W-1:0]  AN_POL   = {AN_W{ACTIVE_LOW}};

  logic [RES_W-1:0] result_q, result_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             sel_q,    sel_d;
  logic [SEG_W-1:0] seg_q,    seg_d;
  logic [AN_W-1:0]  an_q,     an_d;

  bcd_t             bcd_c;
  logic [DIG_W-1:0] digit_c;
  logic [SEG_W-1:0] pattern_c;

  // Capture and refresh timing
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q + CNT_W'(1);
    sel_d    = sel_q;
    if (load) begin
      result_d = {Cout, S};
      valid_d  = 1'b1;
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  // One decoder shared by both digits through the select mux
  always_comb begin
    bcd_c   = to_bcd(BIN_W'(result_q));
    digit_c = sel_q ? bcd_c.tens : bcd_c.units;
  end

  dec7seg u_dec7seg (
    .digit     (digit_c),
    .pattern_c (pattern_c)
  );

  // Active-high frame for the selected digit, tens blanked when zero
  always_comb begin
    seg_d = pattern_c;
    an_d  = sel_q ? AN_DEC : AN_UNI;
    if (sel_q && (bcd_c.tens == '0)) begin
      seg_d = SEG_BLANK;
    end
    if (!valid_q) begin
      seg_d = SEG_BLANK;
      an_d  = AN_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      seg_q    <= SEG_BLANK ^ SEG_POL;
      an_q     <= AN_NONE ^ AN_POL;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d ^ SEG_POL;
      an_q     <= an_d ^ AN_POL;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_display_suma.sv
// Bench for display_suma: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic model of the multiplexed display.
module tb_display_suma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] s5 = '0;
  logic       cout = 1'b0;
  logic       load = 1'b0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b, an_c;
  logic       valid_a, valid_b, valid_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  display_suma #(.N_BITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .S(s5[2:0]), .Cout(cout), .load(load),
    .seg(seg_a), .an(an_a), .valid(valid_a));

  display_suma #(.N_BITS(3), .REFRESH_DIV(1), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .S(s5[2:0]), .Cout(cout), .load(load),
    .seg(seg_b), .an(an_b), .valid(valid_b));

  display_suma #(.N_BITS(5), .REFRESH_DIV(3), .ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .S(s5), .Cout(cout), .load(load),
    .seg(seg_c), .an(an_c), .valid(valid_c));

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected pins after `e` edges since reset, given the value and valid flag then held
  function automatic void frame(input int div, input bit al, input int e, input int res,
                                input bit v, output logic [6:0] seg, output logic [1:0] an);
    logic [6:0] tbl [10];
    int sel;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    sel = (e / div) % 2;
    if (!v) begin
      seg = 7'h00; an = 2'b00;
    end else if (sel == 0) begin
      seg = tbl[res % 10]; an = 2'b01;
    end else begin
      seg = (res / 10 == 0) ? 7'h00 : tbl[res / 10]; an = 2'b10;
    end
    if (al) begin
      seg = ~seg; an = ~an;
    end
  endfunction

  int         e_cnt = 0;
  int         mres3 = 0;
  int         mres5 = 0;
  bit         mvalid = 1'b0;
  logic [6:0] xs_a = 7'h7F, xs_b = 7'h7F, xs_c = 7'h00;
  logic [1:0] xa_a = 2'b11, xa_b = 2'b11, xa_c = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt = 0; mres3 = 0; mres5 = 0; mvalid = 1'b0;
      xs_a = 7'h7F; xa_a = 2'b11;
      xs_b = 7'h7F; xa_b = 2'b11;
      xs_c = 7'h00; xa_c = 2'b00;
    end else begin
      frame(4, 1'b1, e_cnt, mres3, mvalid, xs_a, xa_a);
      frame(1, 1'b1, e_cnt, mres3, mvalid, xs_b, xa_b);
      frame(3, 1'b0, e_cnt, mres5, mvalid, xs_c, xa_c);
      e_cnt++;
      if (load) begin
        mres3  = 8 * int'(cout) + int'(s5[2:0]);
        mres5  = 32 * int'(cout) + int'(s5);
        mvalid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("a_seg", 8'(seg_a), 8'(xs_a));
    check("a_an", 8'(an_a), 8'(xa_a));
    check("a_valid", 8'(valid_a), 8'(mvalid));
    check("b_seg", 8'(seg_b), 8'(xs_b));
    check("b_an", 8'(an_b), 8'(xa_b));
    check("b_valid", 8'(valid_b), 8'(mvalid));
    check("c_seg", 8'(seg_c), 8'(xs_c));
    check("c_an", 8'(an_c), 8'(xa_c));
    check("c_valid", 8'(valid_c), 8'(mvalid));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // 7+7: Cout=1, S=6 -> 14 on 4-bit result, 38 on 6-bit result
    load = 1'b1; cout = 1'b1; s5 = 5'd6;
    edge1();
    @(negedge clk) load = 1'b0;
    edge1();
    check("lit_a_units14_seg", 8'(seg_a), 8'h19);
    check("lit_a_units14_an", 8'(an_a), 8'h02);
    check("lit_b_tens14_seg", 8'(seg_b), 8'h79);
    check("lit_c_units38_seg", 8'(seg_c), 8'h7F);
    check("lit_c_units38_an", 8'(an_c), 8'h01);
    edge1();
    // Load 3 on the terminal-count edge that switches to tens
    @(negedge clk) begin load = 1'b1; cout = 1'b0; s5 = 5'd3; end
    edge1();
    @(negedge clk) load = 1'b0;
    edge1();
    check("lit_a_blank_tens_seg", 8'(seg_a), 8'h7F);
    check("lit_a_blank_tens_an", 8'(an_a), 8'h01);
    repeat (4) edge1();
    check("lit_a_units3_seg", 8'(seg_a), 8'h30);
    check("lit_a_units3_an", 8'(an_a), 8'h02);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_a_seg", 8'(seg_a), 8'h7F);
    check("lit_rst_a_an", 8'(an_a), 8'h03);
    check("lit_rst_a_valid", 8'(valid_a), 8'h00);
    check("lit_rst_c_seg", 8'(seg_c), 8'h00);
    check("lit_rst_c_an", 8'(an_c), 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) edge1();
    check("lit_dark_a_seg", 8'(seg_a), 8'h7F);
    check("lit_dark_a_valid", 8'(valid_a), 8'h00);

    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load = 1'b1; cout = 1'b0; s5 = 5'd10;
    edge1();
    @(negedge clk) load = 1'b0;
    edge1();
    check("lit_c_units10_seg", 8'(seg_c), 8'h3F);
    check("lit_c_units10_an", 8'(an_c), 8'h01);
    check("lit_a_units2_seg", 8'(seg_a), 8'h24);
    edge1();
    edge1();
    check("lit_c_tens10_seg", 8'(seg_c), 8'h06);
    check("lit_c_tens10_an", 8'(an_c), 8'h02);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 2) == 0);
      cout = 1'($urandom);
      s5   = 5'($urandom);
      if (rst_n && $urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
      end else if (!rst_n) begin
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
